quad_steer_decoder: RTL and testbench
=====================================

// Module: quad_steer_decoder
// PURPOSE
//  Quadrature receiver for steering-wheel A/B pairs, i.e. Steer_xA/Steer_xB as produced by the joystick-to-quadrature
//  converter or by a real optical wheel on the user port. Synchronises and de-glitches A/B, then decodes Gray transitions.
//  Outputs a wrapping absolute position plus a saturating delta that is cleared on read, for the CPU steering-read path.
//  One instance per player.
// PARAMETERS
//  FILTER_LEN  4  cycles a new synced A/B value must be stable before acceptance (>=1)
//  POS_W       8  width of wrapping position counter
//  DELTA_W     5  width of signed delta accumulator
//  X4          1  1 = count every edge (4/cycle); 0 = count only on entry to state 00 (1/cycle)
// PORTS
//  CLK       in   1        system clock (clk_12 domain); all logic on rising edge
//  reset     in   1        synchronous, active-high reset
//  quad_a    in   1        raw channel A, asynchronous
//  quad_b    in   1        raw channel B, asynchronous
//  rd        in   1        delta read strobe, one cycle
//  err_clr   in   1        clears sticky err
//  position  out  POS_W    absolute count, modulo 2^POS_W
//  delta     out  DELTA_W  signed counts since last rd, saturating
//  step      out  1        one-cycle pulse per counted step
//  dir       out  1        direction of last counted step: 1 = up (right), 0 = down
//  err       out  1        sticky: illegal transition (both bits changed) seen
// BEHAVIOUR
//  - Reset: position=0, delta=0, step=0, dir=0, err=0, sync FFs=00, filter count=0, FSM=INIT.
//  - Sync: 2-FF synchroniser per channel -> s[1:0]={a,b}.
//  - Filter: cnt resets to 0 whenever s==q (filtered state) or s changes value.
//    - When s!=q has held FILTER_LEN consecutive cycles, q<=s and cnt<=0.
//    - Latency: raw change sampled at edge k -> step high during cycle k+3+FILTER_LEN.
//  - FSM INIT: wait 2 cycles for synchroniser fill, then q<=s with no count and no err -> RUN.
//    Reset mid-operation always re-enters INIT, so a non-00 idle wheel never yields a phantom step.
//  - FSM RUN, on each q update (old->new):
//    - up sequence 00->01->11->10->00: +1, dir<=1.
//    - reverse sequence: -1, dir<=0.
//    - both bits differ: no count, dir unchanged, err<=1.
//    - X4=0: count only on 10->00 (+1) and 01->00 (-1); other legal transitions are silent.
//  - step is registered: high exactly one cycle after each counted q update; never on illegal transitions.
//  - position: wraps (2^POS_W-1)+1=0 and 0-1=2^POS_W-1.
//  - delta: signed, saturates at +(2^(DELTA_W-1)-1) / -(2^(DELTA_W-1)); a saturated step still updates position and step.
//  - rd: delta shows the pre-read value that cycle. Next cycle delta = that cycle's increment (0/+1/-1), so no step is lost.
//  - err: err_clr clears it next cycle; an error in the same cycle as err_clr wins (err stays 1).
// STRUCTURE
//  - quad_pkg:
//    - typedef logic [1:0] quad_t
//    - localparams for the 4 Gray states
//    - function quad_step(old,new) returning {valid,up,illegal}
//    - enum {INIT,RUN} dec_state_t
//  - Sub-module quad_glitch_filter: synchroniser + stability counter, #(FILTER_LEN); outputs q and q_upd pulse.
//  - Top: FSM, decode, position/delta/err registers.
// TESTING
//  1 Reset with A/B held at 11, release, idle 20 cycles -> step never pulses, position=0, err=0.
//  2 FILTER_LEN=4, X4=1: drive up sequence 00,01,11,10,00, 10 cycles each -> 4 step pulses, dir=1, position=4, delta=+4.
//    First step 7 cycles after first pin change.
//  3 Pulse on A lasting 3 cycles (< FILTER_LEN) -> no step, position unchanged.
//    Same pulse held 4 cycles -> one step.
//  4 From position=0, one reverse edge -> position=8'hFF, delta=-1.
//    20 further reverse edges with DELTA_W=5 -> delta=-16, position=8'hEB.
//  5 rd asserted in the same cycle q updates with +1, delta pre-read=+3 -> delta reads 3, next cycle delta=+1.
//  6 Jump 00->11 -> err=1, no step, position held.
//    err_clr together with a 01->10 jump -> err stays 1; a later lone err_clr -> err=0.

Source files
------------

// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared types, Gray states and transition classifier for the quadrature decoder
package quad_pkg;

  typedef logic [1:0] quad_t;

  localparam quad_t Q00 = 2'b00;
  localparam quad_t Q01 = 2'b01;
  localparam quad_t Q11 = 2'b11;
  localparam quad_t Q10 = 2'b10;

  typedef enum logic {INIT, RUN} dec_state_t;

  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } step_t;

  // Up direction follows 00->01->11->10->00; a two-bit change is a missed edge.
  function automatic step_t quad_step(input quad_t old_q, input quad_t new_q);
    step_t r;
    r = '0;
    case ({old_q, new_q})
      {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: begin
        r.valid = 1'b1;
        r.up    = 1'b1;
      end
      {Q01, Q00}, {Q11, Q01}, {Q10, Q11}, {Q00, Q10}: r.valid = 1'b1;
      {Q00, Q11}, {Q11, Q00}, {Q01, Q10}, {Q10, Q01}: r.illegal = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// rtl/quad_glitch_filter.sv - A/B synchroniser plus stability filter producing the accepted quadrature state
module quad_glitch_filter
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  a,
  input  logic  b,
  input  logic  load,
  output quad_t q,
  output quad_t q_prev,
  output logic  q_upd
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  quad_t             s1;
  quad_t             s;
  quad_t             s_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;

  // A fresh value of s counts as its own first stable sample.
  assign cnt_next = (s != s_d) ? CNT_W'(1) : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= Q00;
      s      <= Q00;
      s_d    <= Q00;
      q      <= Q00;
      q_prev <= Q00;
      cnt    <= '0;
      q_upd  <= 1'b0;
    end else begin
      s1    <= {a, b};
      s     <= s1;
      s_d   <= s;
      q_upd <= 1'b0;
      if (load) begin
        q      <= s;
        q_prev <= s;
        cnt    <= '0;
      end else if (s == q) begin
        cnt <= '0;
      end else if (cnt_next == CNT_W'(FILTER_LEN)) begin
        q_prev <= q;
        q      <= s;
        cnt    <= '0;
        q_upd  <= 1'b1;
      end else begin
        cnt <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/quad_steer_decoder.sv
// rtl/quad_steer_decoder.sv - steering quadrature decoder with wrapping position and read-clear saturating delta
module quad_steer_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int POS_W      = 8,
  parameter int DELTA_W    = 5,
  parameter int X4         = 1
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               quad_a,
  input  logic               quad_b,
  input  logic               rd,
  input  logic               err_clr,
  output logic [POS_W-1:0]   position,
  output logic [DELTA_W-1:0] delta,
  output logic               step,
  output logic               dir,
  output logic               err
);

  localparam logic [DELTA_W-1:0] DELTA_MAX = {1'b0, {(DELTA_W-1){1'b1}}};
  localparam logic [DELTA_W-1:0] DELTA_MIN = {1'b1, {(DELTA_W-1){1'b0}}};

  quad_t      q;
  quad_t      q_prev;
  logic       q_upd;
  logic       load;
  logic       init_cnt;
  dec_state_t state;
  step_t      dec;
  logic       counted;
  logic       illegal_seen;

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk    (CLK),
    .reset  (reset),
    .a      (quad_a),
    .b      (quad_b),
    .load   (load),
    .q      (q),
    .q_prev (q_prev),
    .q_upd  (q_upd)
  );

  always_comb begin
    dec          = quad_step(q_prev, q);
    counted      = (state == RUN) && q_upd && dec.valid && ((X4 != 0) || (q == Q00));
    illegal_seen = (state == RUN) && q_upd && dec.illegal;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= 1'b0;
      load     <= 1'b0;
      position <= '0;
      delta    <= '0;
      step     <= 1'b0;
      dir      <= 1'b0;
      err      <= 1'b0;
    end else begin
      load <= 1'b0;
      // Give the synchroniser two cycles, then adopt the wheel's resting state silently.
      case (state)
        INIT: begin
          if (init_cnt) begin
            load  <= 1'b1;
            state <= RUN;
          end else begin
            init_cnt <= 1'b1;
          end
        end
        RUN: state <= RUN;
        default: state <= INIT;
      endcase

      step <= counted;
      if (counted) begin
        dir      <= dec.up;
        position <= dec.up ? position + POS_W'(1) : position - POS_W'(1);
      end

      // A read restarts accumulation with this cycle's increment so no step is lost.
      if (rd) begin
        if (counted) delta <= dec.up ? DELTA_W'(1) : {DELTA_W{1'b1}};
        else         delta <= '0;
      end else if (counted) begin
        if (dec.up && (delta != DELTA_MAX))       delta <= delta + DELTA_W'(1);
        else if (!dec.up && (delta != DELTA_MIN)) delta <= delta - DELTA_W'(1);
      end

      if (illegal_seen) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_steer_decoder.sv
// tb/tb_quad_steer_decoder.sv - directed vector bench for quad_steer_decoder
module tb_quad_steer_decoder;

  logic       CLK = 1'b0;
  logic       reset;
  logic       quad_a;
  logic       quad_b;
  logic       rd;
  logic       err_clr;
  logic [7:0] position;
  logic [4:0] delta;
  logic       step;
  logic       dir;
  logic       err;

  int checks   = 0;
  int errors   = 0;
  int step_cnt = 0;

  typedef struct {
    logic [1:0] ab;
    int         hold;
    int         steps;
    logic [7:0] pos;
    logic [4:0] dlt;
    logic       dir;
  } vec_t;

  vec_t       vecs [8];
  logic [1:0] rev  [4];

  quad_steer_decoder #(
    .FILTER_LEN (4),
    .POS_W      (8),
    .DELTA_W    (5),
    .X4         (1)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .quad_a   (quad_a),
    .quad_b   (quad_b),
    .rd       (rd),
    .err_clr  (err_clr),
    .position (position),
    .delta    (delta),
    .step     (step),
    .dir      (dir),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    if (step) step_cnt++;
  endtask

  task automatic hold_ab(input logic [1:0] ab, input int n);
    {quad_a, quad_b} = ab;
    step_cnt = 0;
    repeat (n) cyc();
  endtask

  task automatic do_reset(input logic [1:0] ab);
    {quad_a, quad_b} = ab;
    rd      = 1'b0;
    err_clr = 1'b0;
    reset   = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
  endtask

  initial begin
    int first;
    int total;
    vecs[0] = '{2'b11, 10, 1, 8'd2, 5'd2, 1'b1};
    vecs[1] = '{2'b10, 10, 1, 8'd3, 5'd3, 1'b1};
    vecs[2] = '{2'b00, 10, 1, 8'd4, 5'd4, 1'b1};
    vecs[3] = '{2'b10,  3, 0, 8'd4, 5'd4, 1'b1};
    vecs[4] = '{2'b00, 10, 0, 8'd4, 5'd4, 1'b1};
    vecs[5] = '{2'b10,  4, 0, 8'd4, 5'd4, 1'b1};
    vecs[6] = '{2'b00,  3, 1, 8'd3, 5'd3, 1'b0};
    vecs[7] = '{2'b00, 10, 1, 8'd4, 5'd4, 1'b1};
    rev[0] = 2'b11; rev[1] = 2'b01; rev[2] = 2'b00; rev[3] = 2'b10;

    // Reset with an idle wheel resting at 11.
    do_reset(2'b11);
    check("reset_position", position, 8'd0);
    check("reset_delta", delta, 5'd0);
    check("reset_step", step, 1'b0);
    check("reset_dir", dir, 1'b0);
    check("reset_err", err, 1'b0);
    hold_ab(2'b11, 20);
    check("idle11_steps", step_cnt, 0);
    check("idle11_position", position, 8'd0);
    check("idle11_err", err, 1'b0);

    // Up sequence with latency measurement on the first edge.
    do_reset(2'b00);
    repeat (25) cyc();
    {quad_a, quad_b} = 2'b01;
    first = -1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (step && first < 0) first = c;
    end
    check("first_step_latency", first, 7);
    check("up1_position", position, 8'd1);
    check("up1_dir", dir, 1'b1);

    for (int i = 0; i < 8; i++) begin
      hold_ab(vecs[i].ab, vecs[i].hold);
      check($sformatf("vec%0d_steps", i), step_cnt, vecs[i].steps);
      check($sformatf("vec%0d_position", i), position, vecs[i].pos);
      check($sformatf("vec%0d_delta", i), delta, vecs[i].dlt);
      check($sformatf("vec%0d_dir", i), dir, vecs[i].dir);
    end

    // Reverse from zero: wrap and saturate at the negative limit.
    do_reset(2'b00);
    repeat (25) cyc();
    hold_ab(2'b10, 10);
    check("rev1_steps", step_cnt, 1);
    check("rev1_position", position, 8'hFF);
    check("rev1_delta", delta, 5'h1F);
    check("rev1_dir", dir, 1'b0);
    total = 0;
    for (int i = 0; i < 20; i++) begin
      hold_ab(rev[i % 4], 10);
      total += step_cnt;
    end
    check("rev21_steps", total, 20);
    check("rev21_position", position, 8'hEB);
    check("rev21_delta", delta, 5'h10);
    check("rev21_dir", dir, 1'b0);

    // Read strobe coinciding with the cycle a +1 step is decoded.
    do_reset(2'b00);
    repeat (25) cyc();
    hold_ab(2'b01, 10);
    hold_ab(2'b11, 10);
    hold_ab(2'b10, 10);
    check("rd_pre_delta", delta, 5'd3);
    {quad_a, quad_b} = 2'b00;
    repeat (6) cyc();
    rd = 1'b1;
    check("rd_cycle_delta", delta, 5'd3);
    check("rd_cycle_step", step, 1'b0);
    cyc();
    rd = 1'b0;
    check("rd_next_delta", delta, 5'd1);
    check("rd_next_step", step, 1'b1);
    check("rd_next_position", position, 8'd4);
    cyc();
    check("rd_after_delta", delta, 5'd1);

    // Illegal jumps, sticky err, and err_clr priority.
    do_reset(2'b00);
    repeat (25) cyc();
    hold_ab(2'b11, 10);
    check("jump_err", err, 1'b1);
    check("jump_steps", step_cnt, 0);
    check("jump_position", position, 8'd0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("clr_err", err, 1'b0);
    hold_ab(2'b01, 10);
    check("legal_position", position, 8'hFF);
    check("legal_err", err, 1'b0);
    {quad_a, quad_b} = 2'b10;
    step_cnt = 0;
    repeat (6) cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("clr_collide_err", err, 1'b1);
    repeat (5) cyc();
    check("clr_collide_steps", step_cnt, 0);
    check("clr_collide_position", position, 8'hFF);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    check("late_clr_err", err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
